// File: rtl/mod_sub_stream_feeder_pkg.sv
// Shared types for the modular add/sub datapath: coefficient width and type,
// subtractor pipeline depth, and the width helper for credit counters.
// Pure declarations; no logic, no latency, no flow control.
package modring_pkg;
   // Coefficient / modulus width in bits.
   localparam int K       = 54;
   // Pipeline depth of the modular subtractor.
   localparam int SUB_LAT = 2;

   typedef logic [K-1:0] coeff_t;

   // Bits needed to hold a credit count ranging over 0..depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/mod_sub_stream_feeder_if.sv
// Stream bundle for the subtractor feeder: A/B operand inputs and result output.
// Carries only wires; timing is set by whoever drives the modports.
// Each stream uses valid/ready; a beat moves when both are high at a clock edge.
interface mod_sub_stream_feeder_if;
   import modring_pkg::*;

   logic   a_valid;
   coeff_t a_data;
   logic   a_ready;
   logic   b_valid;
   coeff_t b_data;
   logic   b_ready;
   logic   out_valid;
   coeff_t out_data;
   logic   out_ready;

   // Environment side: produces operands, consumes results.
   modport master (
      output a_valid, a_data, b_valid, b_data, out_ready,
      input  a_ready, b_ready, out_valid, out_data
   );

   // Feeder side.
   modport slave (
      input  a_valid, a_data, b_valid, b_data, out_ready,
      output a_ready, b_ready, out_valid, out_data
   );
endinterface

// File: rtl/mod_sub_stream_feeder_fifo.sv
// Generic synchronous FIFO with registered storage; head is the oldest entry.
// Latency: a pushed word is visible at head the cycle after the push edge.
// Push when full is honoured only together with a pop; head reads 0 when empty.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB separates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/mod_sub_stream_feeder_sub.sv
// Two-stage modular subtractor: r = (a - b) mod q for a, b in [0,q).
// Latency: 2 cycles from operands to r; fully pipelined, one pair per cycle.
// No flow control; validity is tracked by the caller.
module mod_sub
   import modring_pkg::*;
(
   input  logic   clk,
   input  coeff_t a,
   input  coeff_t b,
   input  coeff_t q,
   output coeff_t r
);
   logic [K:0] diff_s1;
   coeff_t     q_s1;

   // Stage 1: raw difference with a borrow bit above the K data bits.
   always_ff @(posedge clk) begin
      diff_s1 <= {1'b0, a} - {1'b0, b};
      q_s1    <= q;
   end

   // Stage 2: a borrow means a<b, so fold back into range by adding q.
   always_ff @(posedge clk) begin
      r <= diff_s1[K] ? (diff_s1[K-1:0] + q_s1) : diff_s1[K-1:0];
   end
endmodule

// File: rtl/mod_sub_stream_feeder.sv
// Pairs A/B operand streams, runs them through mod_sub, buffers results for out.
// Latency: 4 cycles from an idle accept to out_valid (FIFO write, issue, 2 sub stages).
// Issue only with an obuf credit, so results never back up into the pipe; ready = FIFO not full.
// Optional MOD_SUB_RANGE_CHECK_EN: sticky range_err when an issued operand is >= q.
module mod_sub_stream_feeder
   import modring_pkg::*;
#(
   parameter int IN_DEPTH   = 4,
   parameter int OBUF_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  coeff_t                  q,
   mod_sub_stream_feeder_if.slave  s,
   output logic                    busy,
   output logic                    range_err
);
   localparam int CW = credit_w(OBUF_DEPTH);

   coeff_t              a_head;
   coeff_t              b_head;
   coeff_t              sub_r;
   logic                a_full, a_empty;
   logic                b_full, b_empty;
   logic                o_full, o_empty;
   logic                issue;
   logic                out_pop;
   logic [SUB_LAT-1:0]  pipe_valid;
   logic [CW-1:0]       credits;

   assign s.a_ready = !a_full;
   assign s.b_ready = !b_full;
   assign issue     = !a_empty && !b_empty && (credits != '0);
   assign out_pop   = !o_empty && s.out_ready;
   assign s.out_valid = !o_empty;
   assign busy      = !a_empty || !b_empty || (|pipe_valid) || !o_empty;

   sync_fifo #(.DEPTH(IN_DEPTH), .W(K)) u_fifo_a (
      .clk(clk), .rst(rst),
      .push(s.a_valid && !a_full), .push_data(s.a_data),
      .pop(issue), .head(a_head), .full(a_full), .empty(a_empty)
   );

   sync_fifo #(.DEPTH(IN_DEPTH), .W(K)) u_fifo_b (
      .clk(clk), .rst(rst),
      .push(s.b_valid && !b_full), .push_data(s.b_data),
      .pop(issue), .head(b_head), .full(b_full), .empty(b_empty)
   );

   mod_sub u_sub (
      .clk(clk), .a(a_head), .b(b_head), .q(q), .r(sub_r)
   );

   // Result buffer; credits guarantee a free slot for every issued pair.
   sync_fifo #(.DEPTH(OBUF_DEPTH), .W(K)) u_obuf (
      .clk(clk), .rst(rst),
      .push(pipe_valid[SUB_LAT-1]), .push_data(sub_r),
      .pop(out_pop), .head(s.out_data), .full(o_full), .empty(o_empty)
   );

   // Marks which subtractor stages hold a live pair; reset drops them all.
   always_ff @(posedge clk) begin
      if (rst) pipe_valid <= '0;
      else     pipe_valid <= {pipe_valid[SUB_LAT-2:0], issue};
   end

   // Free obuf slots not yet claimed: spend on issue, refund on pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits <= CW'(OBUF_DEPTH);
      end else begin
         case ({issue, out_pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
      end
   end

`ifdef MOD_SUB_RANGE_CHECK_EN
   // Sticky flag for any issued operand outside [0,q); data still flows.
   always_ff @(posedge clk) begin
      if (rst)                                       range_err <= 1'b0;
      else if (issue && (a_head >= q || b_head >= q)) range_err <= 1'b1;
   end
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_sub_stream_feeder.sv
// Randomized scoreboard bench for mod_sub_stream_feeder.
// Stimulus pushes expected results into a queue; a monitor pops on each output beat.
// Reference: (a-b) mod q by plain arithmetic over FIFO-ordered pairs.
module tb_mod_sub_stream_feeder;
   import modring_pkg::*;

   localparam int IN_DEPTH   = 4;
   localparam int OBUF_DEPTH = 4;

   typedef struct {
      longint unsigned val;
      bit              dc;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst;
   coeff_t q;
   logic   busy;
   logic   range_err;

   mod_sub_stream_feeder_if io();

   mod_sub_stream_feeder #(.IN_DEPTH(IN_DEPTH), .OBUF_DEPTH(OBUF_DEPTH)) dut (
      .clk(clk), .rst(rst), .q(q), .s(io), .busy(busy), .range_err(range_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   longint unsigned qa[$];
   longint unsigned qb[$];
   exp_t            expq[$];
   longint unsigned qv;
   bit              a_took = 0;
   bit              b_took = 0;
   int              acc_a = 0, acc_b = 0, out_cnt = 0, cyc = 0;
   int              first_pop = -1, last_pop = -1;
   longint unsigned ta, tb;
   exp_t            te, me;

   function automatic longint unsigned ref_sub(longint unsigned a, longint unsigned b,
                                               longint unsigned m);
      if (a >= b) return a - b;
      return m - (b - a);
   endfunction

   function automatic longint unsigned rand_coeff(longint unsigned m);
      longint unsigned r;
      r = {$urandom, $urandom};
      case ($urandom_range(7))
         0:       return 0;
         1:       return m - 1;
         default: return r % m;
      endcase
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, req);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Input tap: record accepted beats and form FIFO-ordered pairs into the scoreboard.
   always @(negedge clk) begin
      a_took = 0;
      b_took = 0;
      if (rst) begin
         qa.delete();
         qb.delete();
         expq.delete();
      end else begin
         if (io.a_valid && io.a_ready) begin
            qa.push_back(64'(io.a_data)); acc_a++; a_took = 1;
         end
         if (io.b_valid && io.b_ready) begin
            qb.push_back(64'(io.b_data)); acc_b++; b_took = 1;
         end
         while (qa.size() > 0 && qb.size() > 0) begin
            ta = qa.pop_front();
            tb = qb.pop_front();
            te.dc  = (ta >= qv) || (tb >= qv);
            te.val = te.dc ? 64'd0 : ref_sub(ta, tb, qv);
            expq.push_back(te);
         end
      end
   end

   // Output monitor: every beat taken downstream is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && io.out_valid && io.out_ready) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0d expected=none", io.out_data);
         end else begin
            me = expq.pop_front();
            if (!me.dc) check("sb_data", 64'(io.out_data), me.val);
         end
         out_cnt++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      io.a_valid = 1'b0;
      io.b_valid = 1'b0;
   endtask

   task automatic set_q(longint unsigned v);
      q  = coeff_t'(v);
      qv = v;
   endtask

   task automatic drain(int budget);
      int n;
      n = 0;
      idle();
      io.out_ready = 1'b1;
      while ((busy || expq.size() != 0) && n < budget) begin
         tick(1);
         n++;
      end
      if (n >= budget) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=busy expected=idle");
      end
   endtask

   // Directed pair from idle: checks first-result latency and value.
   task automatic send_pair(string name, longint unsigned a, longint unsigned b,
                            longint unsigned req);
      int lat;
      io.out_ready = 1'b1;
      io.a_valid = 1'b1; io.a_data = coeff_t'(a);
      io.b_valid = 1'b1; io.b_data = coeff_t'(b);
      tick(1);
      idle();
      lat = 0;
      while (!io.out_valid && lat < 10) begin
         tick(1);
         lat++;
      end
      // Three edges after the accept edge: 4 cycles counting the accept cycle.
      check({name, "_lat"}, 64'(lat), 64'd3);
      check({name, "_data"}, 64'(io.out_data), req);
      drain(50);
   endtask

   // Random streams of n pairs with independent A/B valids and random out_ready.
   task automatic run_stream(int n, int pv, int pr);
      int na, nb, guard;
      na = 0; nb = 0; guard = 0;
      idle();
      while ((na < n || nb < n) && guard < 20000) begin
         tick(1);
         guard++;
         if (a_took) na++;
         if (b_took) nb++;
         if (!io.a_valid || a_took) begin
            io.a_valid = (na < n) && ($urandom_range(99) < pv);
            io.a_data  = coeff_t'(rand_coeff(qv));
         end
         if (!io.b_valid || b_took) begin
            io.b_valid = (nb < n) && ($urandom_range(99) < pv);
            io.b_data  = coeff_t'(rand_coeff(qv));
         end
         io.out_ready = ($urandom_range(99) < pr);
      end
      if (guard >= 20000) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout actual=%0d/%0d expected=%0d", na, nb, n);
      end
      idle();
   endtask

   initial begin
      int o0, a0, b0;
      longint unsigned qbig;
      qbig = (64'd1 << 54) - 64'd33;
      rst = 1'b1;
      set_q(97);
      idle();
      io.a_data = '0; io.b_data = '0; io.out_ready = 1'b0;
      tick(3);
      rst = 1'b0;
      check("rst_out_valid", 64'(io.out_valid), 64'd0);
      check("rst_out_data",  64'(io.out_data),  64'd0);
      check("rst_busy",      64'(busy),         64'd0);
      check("rst_range_err", 64'(range_err),    64'd0);
      check("rst_a_ready",   64'(io.a_ready),   64'd1);
      check("rst_b_ready",   64'(io.b_ready),   64'd1);

      // Small modulus: normal, borrow and zero cases.
      send_pair("t1", 10, 3, 7);
      send_pair("t2a", 3, 10, 90);
      send_pair("t2b", 0, 0, 0);
      send_pair("t2c", 96, 96, 0);

      // Large modulus with bit K-1 set: wrap path.
      set_q(qbig);
      send_pair("t3a", 0, qbig - 1, 1);
      send_pair("t3b", qbig - 1, 0, qbig - 1);

      // Full-rate stream: 64 results back to back.
      set_q(97);
      o0 = out_cnt;
      first_pop = -1;
      run_stream(64, 100, 100);
      drain(200);
      check("t4_count", 64'(out_cnt - o0), 64'd64);
      check("t4_span",  64'(last_pop - first_pop), 64'd63);

      // Random traffic, small and large moduli.
      run_stream(150, 60, 70);
      drain(500);
      set_q(qbig);
      run_stream(150, 80, 50);
      drain(500);
      set_q({$urandom, $urandom} & ((64'd1 << 54) - 1) | (64'd1 << 53));
      run_stream(100, 70, 70);
      drain(500);

      // Downstream stall with both streams pushing.
      set_q(97);
      io.out_ready = 1'b0;
      a0 = acc_a; b0 = acc_b; o0 = out_cnt;
      repeat (20) begin
         tick(1);
         if (!io.a_valid || a_took) begin
            io.a_valid = 1'b1; io.a_data = coeff_t'(rand_coeff(qv));
         end
         if (!io.b_valid || b_took) begin
            io.b_valid = 1'b1; io.b_data = coeff_t'(rand_coeff(qv));
         end
      end
      check("t5_a_ready",   64'(io.a_ready),  64'd0);
      check("t5_b_ready",   64'(io.b_ready),  64'd0);
      check("t5_out_valid", 64'(io.out_valid), 64'd1);
      check("t5_acc_a", 64'(acc_a - a0), 64'(IN_DEPTH + OBUF_DEPTH));
      check("t5_acc_b", 64'(acc_b - b0), 64'(IN_DEPTH + OBUF_DEPTH));
      drain(100);
      check("t5_drained", 64'(out_cnt - o0), 64'(IN_DEPTH + OBUF_DEPTH));

      // Reset with three pairs in flight.
      io.out_ready = 1'b0;
      repeat (3) begin
         io.a_valid = 1'b1; io.a_data = coeff_t'(rand_coeff(qv));
         io.b_valid = 1'b1; io.b_data = coeff_t'(rand_coeff(qv));
         tick(1);
      end
      idle();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t6_out_valid", 64'(io.out_valid), 64'd0);
      check("t6_busy",      64'(busy),         64'd0);
      check("t6_out_data",  64'(io.out_data),  64'd0);
      tick(4);
      check("t6_no_ghost",  64'(io.out_valid), 64'd0);
      send_pair("t6_fresh", 5, 9, 93);

`ifdef MOD_SUB_RANGE_CHECK_EN
      io.out_ready = 1'b1;
      io.a_valid = 1'b1; io.a_data = coeff_t'(97);
      io.b_valid = 1'b1; io.b_data = coeff_t'(1);
      tick(1);
      drain(50);
      check("t7_range_set", 64'(range_err), 64'd1);
      send_pair("t7_after", 20, 30, 87);
      check("t7_range_sticky", 64'(range_err), 64'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("t7_range_clr", 64'(range_err), 64'd0);
`else
      check("range_err_tied", 64'(range_err), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog actual=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
